// File: rtl/ysyx_22040237_lsu.sv
// Multi-cycle load/store unit between execute and write-back.
// Drives a valid/ready data-memory port and returns extended results.
module ysyx_22040237_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [6:0]  ls_info_bus_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    input  logic        rd_wr_en_i,
    input  logic [4:0]  rd_idx_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [63:0] mem_req_addr_o,
    output logic        mem_req_wen_o,
    output logic [63:0] mem_req_wdata_o,
    output logic [7:0]  mem_req_wstrb_o,
    input  logic        mem_rsp_valid_i,
    input  logic [63:0] mem_rsp_rdata_i,
    input  logic        mem_rsp_err_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [63:0] wb_data_o,
    output logic        rd_wr_en_o,
    output logic [4:0]  rd_idx_o,
    output logic        lsu_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

    state_e      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        wen_q, wen_d;
    logic [6:0]  info_q, info_d;
    logic        rd_en_q, rd_en_d;
    logic [4:0]  rd_idx_q, rd_idx_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic        err_q, err_d;
    logic        wb_en_q, wb_en_d;

    logic        ld, st, dw, wd, hw, by, size_ok, illegal, misal;
    logic [7:0]  mask;
    logic [63:0] sh, ld_res;

    assign ld = ls_info_bus_i[0];
    assign st = ls_info_bus_i[1];
    assign by = ls_info_bus_i[3];
    assign hw = ls_info_bus_i[4];
    assign wd = ls_info_bus_i[5];
    assign dw = ls_info_bus_i[6];

    assign size_ok = (ls_info_bus_i[6:3] == 4'b0001)
                   | (ls_info_bus_i[6:3] == 4'b0010)
                   | (ls_info_bus_i[6:3] == 4'b0100)
                   | (ls_info_bus_i[6:3] == 4'b1000);
    assign illegal = (ld & st) | ((ld | st) & ~size_ok);
    assign misal   = (hw & addr_i[0])
                   | (wd & (addr_i[1:0] != 2'b00))
                   | (dw & (addr_i[2:0] != 3'b000));
    // Only meaningful once the size field is known to be one-hot.
    assign mask = {{4{dw}}, {2{dw | wd}}, dw | wd | hw, 1'b1};

    assign sh = mem_rsp_rdata_i >> {addr_q[2:0], 3'b000};

    always_comb begin
        ld_res = sh;
        if (info_q[3])
            ld_res = info_q[2] ? {56'b0, sh[7:0]}
                               : {{56{sh[7]}}, sh[7:0]};
        else if (info_q[4])
            ld_res = info_q[2] ? {48'b0, sh[15:0]}
                               : {{48{sh[15]}}, sh[15:0]};
        else if (info_q[5])
            ld_res = info_q[2] ? {32'b0, sh[31:0]}
                               : {{32{sh[31]}}, sh[31:0]};
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wen_d     = wen_q;
        info_d    = info_q;
        rd_en_d   = rd_en_q;
        rd_idx_d  = rd_idx_q;
        wb_data_d = wb_data_q;
        err_d     = err_q;
        wb_en_d   = wb_en_q;
        unique case (state_q)
            IDLE: begin
                if (lsu_valid_i) begin
                    addr_d   = addr_i;
                    info_d   = ls_info_bus_i;
                    rd_en_d  = rd_wr_en_i;
                    rd_idx_d = rd_idx_i;
                    wen_d    = st;
                    wdata_d  = wdata_i << {addr_i[2:0], 3'b000};
                    wstrb_d  = st ? (mask << addr_i[2:0]) : 8'h00;
                    if (!ld && !st) begin
                        state_d   = DONE;
                        wb_data_d = addr_i;
                        err_d     = 1'b0;
                        wb_en_d   = rd_wr_en_i;
                    end else if (illegal || misal) begin
                        state_d   = DONE;
                        wb_data_d = 64'h0;
                        err_d     = 1'b1;
                        wb_en_d   = 1'b0;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready_i) state_d = RESP;
            end
            RESP: begin
                if (mem_rsp_valid_i) begin
                    state_d = DONE;
                    err_d   = mem_rsp_err_i;
                    if (mem_rsp_err_i || info_q[1] || !info_q[0]) begin
                        wb_data_d = 64'h0;
                        wb_en_d   = 1'b0;
                    end else begin
                        wb_data_d = ld_res;
                        wb_en_d   = rd_en_q;
                    end
                end
            end
            DONE: begin
                if (wb_ready_i) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= 64'h0;
            wdata_q   <= 64'h0;
            wstrb_q   <= 8'h0;
            wen_q     <= 1'b0;
            info_q    <= 7'h0;
            rd_en_q   <= 1'b0;
            rd_idx_q  <= 5'h0;
            wb_data_q <= 64'h0;
            err_q     <= 1'b0;
            wb_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wen_q     <= wen_d;
            info_q    <= info_d;
            rd_en_q   <= rd_en_d;
            rd_idx_q  <= rd_idx_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
            wb_en_q   <= wb_en_d;
        end
    end

    logic in_req, in_done;
    assign in_req  = (state_q == REQ);
    assign in_done = (state_q == DONE);

    assign lsu_ready_o     = (state_q == IDLE);
    assign mem_req_valid_o = in_req;
    assign mem_req_addr_o  = in_req ? {addr_q[63:3], 3'b000} : 64'h0;
    assign mem_req_wen_o   = in_req & wen_q;
    assign mem_req_wdata_o = in_req ? wdata_q : 64'h0;
    assign mem_req_wstrb_o = in_req ? wstrb_q : 8'h0;
    assign wb_valid_o      = in_done;
    assign wb_data_o       = in_done ? wb_data_q : 64'h0;
    assign rd_wr_en_o      = in_done & wb_en_q;
    assign rd_idx_o        = in_done ? rd_idx_q : 5'h0;
    assign lsu_err_o       = in_done & err_q;

endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// Directed self-checking bench for ysyx_22040237_lsu.
module tb_ysyx_22040237_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [6:0]  ls_info_bus_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic        rd_wr_en_i;
    logic [4:0]  rd_idx_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [63:0] mem_req_addr_o;
    logic        mem_req_wen_o;
    logic [63:0] mem_req_wdata_o;
    logic [7:0]  mem_req_wstrb_o;
    logic        mem_rsp_valid_i;
    logic [63:0] mem_rsp_rdata_i;
    logic        mem_rsp_err_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [63:0] wb_data_o;
    logic        rd_wr_en_o;
    logic [4:0]  rd_idx_o;
    logic        lsu_err_o;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_22040237_lsu dut (
        .clk             (clk),
        .rst             (rst),
        .lsu_valid_i     (lsu_valid_i),
        .lsu_ready_o     (lsu_ready_o),
        .ls_info_bus_i   (ls_info_bus_i),
        .addr_i          (addr_i),
        .wdata_i         (wdata_i),
        .rd_wr_en_i      (rd_wr_en_i),
        .rd_idx_i        (rd_idx_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_wen_o   (mem_req_wen_o),
        .mem_req_wdata_o (mem_req_wdata_o),
        .mem_req_wstrb_o (mem_req_wstrb_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_rdata_i (mem_rsp_rdata_i),
        .mem_rsp_err_i   (mem_rsp_err_i),
        .wb_valid_o      (wb_valid_o),
        .wb_ready_i      (wb_ready_i),
        .wb_data_o       (wb_data_o),
        .rd_wr_en_o      (rd_wr_en_o),
        .rd_idx_o        (rd_idx_o),
        .lsu_err_o       (lsu_err_o)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] info, input logic [63:0] a,
                         input logic [63:0] wd, input logic en,
                         input logic [4:0] rd);
        lsu_valid_i   = 1'b1;
        ls_info_bus_i = info;
        addr_i        = a;
        wdata_i       = wd;
        rd_wr_en_i    = en;
        rd_idx_i      = rd;
        tick();
        lsu_valid_i   = 1'b0;
        ls_info_bus_i = 7'h0;
        addr_i        = 64'h0;
        wdata_i       = 64'h0;
    endtask

    task automatic req_accept();
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
    endtask

    task automatic respond(input logic [63:0] rd, input logic er);
        mem_rsp_valid_i = 1'b1;
        mem_rsp_rdata_i = rd;
        mem_rsp_err_i   = er;
        tick();
        mem_rsp_valid_i = 1'b0;
        mem_rsp_rdata_i = 64'h0;
        mem_rsp_err_i   = 1'b0;
    endtask

    task automatic take();
        wb_ready_i = 1'b1;
        tick();
        wb_ready_i = 1'b0;
        check("idle_ready", lsu_ready_o, 1);
        check("idle_wbv", wb_valid_o, 0);
    endtask

    task automatic load(input string tag, input logic [6:0] info,
                        input logic [63:0] a, input logic [63:0] rd,
                        input logic [63:0] exp);
        issue(info, a, 64'h0, 1'b1, 5'd9);
        check({tag, "_reqv"}, mem_req_valid_o, 1);
        check({tag, "_addr"}, mem_req_addr_o, {a[63:3], 3'b000});
        check({tag, "_strb"}, mem_req_wstrb_o, 0);
        check({tag, "_wen"}, mem_req_wen_o, 0);
        req_accept();
        check({tag, "_resp_wbv"}, wb_valid_o, 0);
        respond(rd, 1'b0);
        check({tag, "_wbv"}, wb_valid_o, 1);
        check({tag, "_data"}, wb_data_o, exp);
        check({tag, "_rden"}, rd_wr_en_o, 1);
        check({tag, "_rd"}, rd_idx_o, 9);
        check({tag, "_err"}, lsu_err_o, 0);
        take();
    endtask

    initial begin
        rst = 1'b0;
        lsu_valid_i = 0; ls_info_bus_i = 0; addr_i = 0; wdata_i = 0;
        rd_wr_en_i = 0; rd_idx_i = 0; mem_req_ready_i = 0;
        mem_rsp_valid_i = 0; mem_rsp_rdata_i = 0; mem_rsp_err_i = 0;
        wb_ready_i = 0;
        tick(); tick();
        check("rst_ready", lsu_ready_o, 1);
        check("rst_reqv", mem_req_valid_o, 0);
        check("rst_addr", mem_req_addr_o, 0);
        check("rst_strb", mem_req_wstrb_o, 0);
        check("rst_wbv", wb_valid_o, 0);
        check("rst_data", wb_data_o, 0);
        check("rst_err", lsu_err_o, 0);
        rst = 1'b1;
        tick();

        // pass-through
        issue(7'h00, 64'h1234, 64'h0, 1'b1, 5'd5);
        check("pt_wbv", wb_valid_o, 1);
        check("pt_data", wb_data_o, 64'h1234);
        check("pt_rd", rd_idx_o, 5);
        check("pt_rden", rd_wr_en_o, 1);
        check("pt_err", lsu_err_o, 0);
        check("pt_reqv", mem_req_valid_o, 0);
        check("pt_ready", lsu_ready_o, 0);
        take();

        load("lb", 7'h09, 64'h8000_0003, 64'h0000_0000_8000_0000,
             64'hFFFF_FFFF_FFFF_FF80);
        load("lbu", 7'h0D, 64'h8000_0003, 64'h0000_0000_8000_0000,
             64'h0000_0000_0000_0080);
        load("lh", 7'h11, 64'h0000_1002, 64'h0000_0000_F00D_0000,
             64'hFFFF_FFFF_FFFF_F00D);
        load("lwu", 7'h25, 64'h0000_1004, 64'h8765_4321_0000_0000,
             64'h0000_0000_8765_4321);
        load("ld", 7'h45, 64'h0000_1008, 64'h8765_4321_1122_3344,
             64'h8765_4321_1122_3344);

        // half store
        issue(7'h12, 64'h0000_1006, 64'h0000_0000_0000_BEEF, 1'b1, 5'd3);
        check("sh_reqv", mem_req_valid_o, 1);
        check("sh_addr", mem_req_addr_o, 64'h1000);
        check("sh_strb", mem_req_wstrb_o, 8'hC0);
        check("sh_wdata", mem_req_wdata_o, 64'hBEEF_0000_0000_0000);
        check("sh_wen", mem_req_wen_o, 1);
        req_accept();
        respond(64'h0, 1'b0);
        check("sh_wbv", wb_valid_o, 1);
        check("sh_data", wb_data_o, 0);
        check("sh_rden", rd_wr_en_o, 0);
        check("sh_err", lsu_err_o, 0);
        take();

        // misaligned lw
        issue(7'h21, 64'h0000_1002, 64'h0, 1'b1, 5'd7);
        check("mis_wbv", wb_valid_o, 1);
        check("mis_err", lsu_err_o, 1);
        check("mis_rden", rd_wr_en_o, 0);
        check("mis_reqv", mem_req_valid_o, 0);
        take();

        // illegal load+store
        issue(7'h63, 64'h0000_1000, 64'h0, 1'b1, 5'd7);
        check("ill_wbv", wb_valid_o, 1);
        check("ill_err", lsu_err_o, 1);
        check("ill_rden", rd_wr_en_o, 0);
        check("ill_reqv", mem_req_valid_o, 0);
        take();

        // backpressure on both handshakes, bus error
        issue(7'h41, 64'h0000_2000, 64'h0, 1'b1, 5'd4);
        for (int i = 0; i < 3; i++) begin
            mem_rsp_valid_i = (i == 1);
            check("bp_reqv", mem_req_valid_o, 1);
            check("bp_addr", mem_req_addr_o, 64'h2000);
            check("bp_strb", mem_req_wstrb_o, 0);
            check("bp_ready", lsu_ready_o, 0);
            tick();
        end
        mem_rsp_valid_i = 1'b0;
        check("bp_reqv3", mem_req_valid_o, 1);
        req_accept();
        respond(64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
        for (int i = 0; i < 2; i++) begin
            check("bp_wbv", wb_valid_o, 1);
            check("bp_err", lsu_err_o, 1);
            check("bp_data", wb_data_o, 0);
            check("bp_rden", rd_wr_en_o, 0);
            check("bp_ready_wb", lsu_ready_o, 0);
            tick();
        end
        take();

        // reset while waiting for a response
        issue(7'h09, 64'h0000_3000, 64'h0, 1'b1, 5'd2);
        req_accept();
        check("rr_resp_reqv", mem_req_valid_o, 0);
        rst = 1'b0;
        #1;
        check("rr_ready", lsu_ready_o, 1);
        check("rr_reqv", mem_req_valid_o, 0);
        tick();
        rst = 1'b1;
        respond(64'hFF, 1'b0);
        check("rr_wbv", wb_valid_o, 0);
        check("rr_ready2", lsu_ready_o, 1);
        tick();
        check("rr_wbv2", wb_valid_o, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22040237_lsu.md
# ysyx_22040237_lsu

Multi-cycle load/store unit sitting directly after the execute stage. It consumes the execute stage's memory-op bundle: 7-bit LS info bus, 64-bit effective address, store data and rd tag. It drives a 64-bit valid/ready data-memory port, then returns a sign/zero-extended write-back result with its own valid/ready handshake. Non-memory instructions pass through with one cycle of latency.

## Interface
- No parameters; data width fixed at 64, address width 64.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- lsu_valid_i  in  1  upstream op valid.
- lsu_ready_o  out  1  unit can accept; high only in IDLE.
- ls_info_bus_i  in  7  {dw, word, half, byte, usign, store, load}, bit0 = load.
- addr_i  in  64  effective address, also the pass-through ALU result.
- wdata_i  in  64  store data, low-aligned.
- rd_wr_en_i / rd_idx_i  in  1/5  destination tag.
- mem_req_valid_o  out  1  memory request.
- mem_req_ready_i  in  1  memory accepts request.
- mem_req_addr_o  out  64  addr_i with [2:0] cleared.
- mem_req_wen_o  out  1  1 = write.
- mem_req_wdata_o  out  64  store data shifted to byte lane addr[2:0].
- mem_req_wstrb_o  out  8  byte enables; 0 for reads.
- mem_rsp_valid_i  in  1  response/ack.
- mem_rsp_rdata_i  in  64  read data, full doubleword.
- mem_rsp_err_i  in  1  bus error with response.
- wb_valid_o  out  1  result valid.
- wb_ready_i  in  1  write-back accepts.
- wb_data_o  out  64  load result or pass-through address.
- rd_wr_en_o / rd_idx_o  out  1/5  destination tag, registered.
- lsu_err_o  out  1  op faulted; qualifies wb_valid_o.

## Operation
- States: IDLE, REQ, RESP, DONE. Accept = lsu_valid_i & lsu_ready_o in IDLE. Accept latches every input.
- Decode on accept:
  - If load^store = 0 with load|store = 1, the op is illegal. If load or store is set, size bits {dw, word, half, byte} must be exactly one-hot, otherwise illegal.
  - Misaligned when half & addr[0], word & addr[1:0]≠0, or dw & addr[2:0]≠0.
- Transitions from IDLE on accept:
  - Neither load nor store set → DONE with wb_data = addr_i, lsu_err = 0.
  - Illegal or misaligned → DONE with lsu_err = 1 and rd_wr_en_o forced 0. No memory request is issued.
  - Otherwise → REQ.
- REQ: mem_req_valid_o = 1, all req fields held stable. mem_req_ready_i moves the FSM to RESP.
- RESP: waits for mem_rsp_valid_i. On response, captures rdata and err, then → DONE.
- Load extraction: sh = rdata >> (8·addr[2:0]). Result is sh[7:0], sh[15:0], sh[31:0] or sh[63:0] by size, sign-extended from its MSB unless usign; dw ignores usign.
- Store: wstrb = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0]; wdata = wdata_i << 8·addr[2:0]. wb_data = 0 and rd_wr_en_o = 0 for stores.
- Bus error: lsu_err = 1, rd_wr_en_o = 0, wb_data = 0.
- DONE: wb_valid_o = 1 with all outputs stable until wb_ready_i, then → IDLE.

## Timing
- Reset values: state IDLE, lsu_ready_o = 1. All other outputs are 0: mem_req_*, wb_valid_o, wb_data_o, rd_*, lsu_err_o.
- Reset asserted mid-operation returns to IDLE and drops mem_req_valid_o immediately. A response arriving after reset is ignored.
- mem_rsp_valid_i is ignored in IDLE, REQ and DONE.
- Latency for pass-through or fault: accept at cycle N → wb_valid_o at N+1.
- Latency for memory ops: accept at N → mem_req_valid_o at N+1. Req handshake at cycle R; response earliest at R+1; wb_valid_o in the cycle after the response.
- Minimum latency is 3 cycles (accept to wb_valid_o).
- No back-to-back accept: lsu_ready_o is low from N+1 until the cycle after the wb handshake. Throughput is at most one op per 2 cycles for pass-through ops and one op per 4 cycles for memory ops.
- Outputs are registered or state-decoded only; no input→output combinational path except none.

## Test plan
- Pass-through: info = 0, addr = 0x1234, rd_wr_en = 1, rd = 5 → wb_valid at N+1, wb_data = 0x1234, rd_idx = 5, no mem_req.
- Signed byte load: lb at addr 0x8000_0003, rdata = 0x0000_0000_8000_0000, ready = 1, response one cycle later → req addr 0x8000_0000, wstrb = 0, wb_data = 0xFFFF_FFFF_FFFF_FF80 at N+3. The same op with usign → 0x80.
- Half store: sh at addr 0x...06, wdata = 0xBEEF → wstrb = 0xC0, wdata = 0xBEEF_0000_0000_0000, wen = 1, rd_wr_en_o = 0.
- Misaligned: lw at addr 0x...02 → no mem_req, wb_valid at N+1, lsu_err = 1, rd_wr_en_o = 0. Same result for illegal info = 0b1100011 (load+store).
- Backpressure: hold mem_req_ready_i low 3 cycles, then rsp_err = 1; hold wb_ready_i low 2 cycles → req fields and wb outputs stable throughout, lsu_err = 1, lsu_ready_o low until the wb handshake.
- Reset in RESP: assert rst low while waiting, then pulse mem_rsp_valid_i after release → IDLE, no wb_valid, lsu_ready_o = 1.
